// File: rtl/btn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_pkg                                                       |
// | Purpose  : Shared types, constants and helpers for the button            |
// |            conditioner (btn_channel, btn_conditioner).                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package btn_pkg;

    // Per-channel debounce state. HELD and CONFIRM_RELEASE both mean "level = pressed".
    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        HELD            = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } btn_state_t;

    // Depth of the metastability synchroniser on each raw pin.
    localparam int SYNC_STAGES = 2;

    // Bits needed to hold a count from 0 up to n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_channel                                                   |
// | Purpose  : One button channel: 2-FF sync, polarity fix, debounce FSM,    |
// |            one-cycle press/release pulses. Optional auto-repeat of the   |
// |            press pulse when BTN_REPEAT_EN is defined.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module btn_channel
    import btn_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter logic [31:0] REPEAT_DELAY    = 32'd50_000_000,
    parameter logic [31:0] REPEAT_PERIOD   = 32'd10_000_000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W    = cnt_width(int'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
    // Raw pin value while the button is not pressed; also the sync reset value.
    localparam logic             IDLE_RAW = ACTIVE_LOW;

    // Zero-valued counts or periods make the timing meaningless; stop at elaboration.
    if (DEBOUNCE_CYCLES == 16'd0) begin : g_chk_debounce
        $error("btn_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY == 32'd0) begin : g_chk_rep_delay
        $error("btn_channel: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD == 32'd0) begin : g_chk_rep_period
        $error("btn_channel: REPEAT_PERIOD must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level;
    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

`ifdef BTN_REPEAT_EN
    logic [31:0]            rcnt_q, rcnt_d;
    logic                   rfirst_q, rfirst_d;   // first repeat already issued
`endif

    // Synchroniser shift register; reset to the idle pin level so no false press appears.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= {SYNC_STAGES{IDLE_RAW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s     = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;
    assign level = (state_q == HELD) || (state_q == CONFIRM_RELEASE);

    // Debounce decision, pulse generation and optional repeat scheduling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_REPEAT_EN
        rcnt_d    = rcnt_q;
        rfirst_d  = rfirst_q;
`endif
        if (s == level) begin
            // Input agrees with the accepted level: any pending change is abandoned.
            cnt_d   = '0;
            state_d = level ? HELD : IDLE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            state_d   = s ? HELD : IDLE;
            press_d   = s;
            release_d = ~s;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = s ? CONFIRM_PRESS : CONFIRM_RELEASE;
        end
`ifdef BTN_REPEAT_EN
        // rcnt runs only while the accepted level is pressed; a release wins over a repeat.
        if (!level || release_d) begin
            rcnt_d   = '0;
            rfirst_d = 1'b0;
        end else if (rcnt_q == (rfirst_q ? (REPEAT_PERIOD - 32'd1)
                                         : (REPEAT_DELAY - 32'd1))) begin
            press_d  = 1'b1;
            rcnt_d   = '0;
            rfirst_d = 1'b1;
        end else begin
            rcnt_d   = rcnt_q + 32'd1;
        end
`endif
    end

    // State, debounce counter and output pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BTN_REPEAT_EN
    // Auto-repeat counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end
`endif

    assign level_o   = level;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_conditioner                                               |
// | Purpose  : N-channel push-button conditioner: synchronise, debounce and  |
// |            edge-detect raw buttons into clean levels and 1-cycle pulses. |
// |            Define BTN_REPEAT_EN to enable auto-repeat of btn_press.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int          N_BTN           = 4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter logic [31:0] REPEAT_DELAY    = 32'd50_000_000,
    parameter logic [31:0] REPEAT_PERIOD   = 32'd10_000_000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    // Channels are fully independent; one instance per button.
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .Clk       (Clk),
            .Reset     (Reset),
            .raw_i     (btn_raw[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g])
        );
    end

endmodule
`default_nettype wire
